// File: rtl/fwd_hazard_ctrl_if.sv
// Decode-stage view of the forwarding/hazard controller: instruction fields in, operand selects and stall out.
// The master side is the decode stage; the slave side is the controller.
interface fwd_hazard_ctrl_if #(
    parameter int STALL_CNT_W = 16
);
    logic [4:0]             id_rs;
    logic [4:0]             id_rt;
    logic [4:0]             id_rd;
    logic                   id_use_rs;
    logic                   id_use_rt;
    logic                   id_shift;
    logic                   id_aluimm;
    logic                   id_store;
    logic                   id_wreg;
    logic                   id_load;
    logic                   flush;
    logic                   stall;
    logic [1:0]             a_ctrl;
    logic [1:0]             b_ctrl;
    logic [1:0]             sd_ctrl;
    logic [STALL_CNT_W-1:0] stall_count;

    modport master (
        output id_rs, id_rt, id_rd, id_use_rs, id_use_rt, id_shift,
        output id_aluimm, id_store, id_wreg, id_load, flush,
        input  stall, a_ctrl, b_ctrl, sd_ctrl, stall_count
    );

    modport slave (
        input  id_rs, id_rt, id_rd, id_use_rs, id_use_rt, id_shift,
        input  id_aluimm, id_store, id_wreg, id_load, flush,
        output stall, a_ctrl, b_ctrl, sd_ctrl, stall_count
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding/hazard control: ALU operand and store-data selects for EXE, load-use stall, branch flush.
// Selects are registered (valid while the instruction sits in EXE); stall is combinational and freezes PC/IF-ID.
module fwd_hazard_ctrl #(
    parameter int STALL_CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    fwd_hazard_ctrl_if.slave  bus
);

    localparam logic [1:0] SEL_REG = 2'b00;
    localparam logic [1:0] SEL_ALT = 2'b01;
    localparam logic [1:0] SEL_EXE = 2'b10;
    localparam logic [1:0] SEL_MEM = 2'b11;

    // Destinations of the instructions currently in EXE and MEM
    logic       ex_wreg;
    logic       ex_load;
    logic [4:0] ex_rd;
    logic       mem_wreg;
    logic [4:0] mem_rd;

    logic       ex_hit_rs;
    logic       ex_hit_rt;
    logic       mem_hit_rs;
    logic       mem_hit_rt;
    logic       hazard;
    logic       stall_i;
    logic       kill;

    logic [1:0] a_nxt;
    logic [1:0] b_nxt;
    logic [1:0] sd_nxt;
    logic [1:0] a_q;
    logic [1:0] b_q;
    logic [1:0] sd_q;

    logic [STALL_CNT_W-1:0] cnt_q;

    always_comb begin
        ex_hit_rs  = ex_wreg  && (ex_rd  == bus.id_rs) && (bus.id_rs != 5'd0);
        ex_hit_rt  = ex_wreg  && (ex_rd  == bus.id_rt) && (bus.id_rt != 5'd0);
        mem_hit_rs = mem_wreg && (mem_rd == bus.id_rs) && (bus.id_rs != 5'd0);
        mem_hit_rt = mem_wreg && (mem_rd == bus.id_rt) && (bus.id_rt != 5'd0);
    end

    // A shift never reads rs as an operand, so a load into rs cannot stall it
    always_comb begin
        hazard  = ex_load && ((bus.id_use_rs && !bus.id_shift && ex_hit_rs) ||
                              (bus.id_use_rt && ex_hit_rt));
        stall_i = hazard && !bus.flush;
        kill    = stall_i || bus.flush;
    end

    // Youngest producer wins: EXE match is checked before MEM match
    always_comb begin
        a_nxt  = SEL_REG;
        b_nxt  = SEL_REG;
        sd_nxt = SEL_REG;

        if (bus.id_shift) begin
            a_nxt = SEL_ALT;
        end else if (bus.id_use_rs && ex_hit_rs) begin
            a_nxt = SEL_EXE;
        end else if (bus.id_use_rs && mem_hit_rs) begin
            a_nxt = SEL_MEM;
        end

        if (bus.id_aluimm) begin
            b_nxt = SEL_ALT;
        end else if (bus.id_use_rt && ex_hit_rt) begin
            b_nxt = SEL_EXE;
        end else if (bus.id_use_rt && mem_hit_rt) begin
            b_nxt = SEL_MEM;
        end

        if (bus.id_store && bus.id_use_rt) begin
            if (ex_hit_rt) begin
                sd_nxt = SEL_EXE;
            end else if (mem_hit_rt) begin
                sd_nxt = SEL_MEM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_wreg  <= 1'b0;
            ex_load  <= 1'b0;
            ex_rd    <= 5'd0;
            mem_wreg <= 1'b0;
            mem_rd   <= 5'd0;
            a_q      <= SEL_REG;
            b_q      <= SEL_REG;
            sd_q     <= SEL_REG;
        end else begin
            mem_wreg <= ex_wreg;
            mem_rd   <= ex_rd;
            ex_rd    <= bus.id_rd;
            // A stalled or flushed decode slot enters EXE as a bubble
            ex_wreg  <= bus.id_wreg && !kill;
            ex_load  <= bus.id_load && !kill;
            a_q      <= kill ? SEL_REG : a_nxt;
            b_q      <= kill ? SEL_REG : b_nxt;
            sd_q     <= kill ? SEL_REG : sd_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (stall_i && (cnt_q != {STALL_CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.stall       = stall_i;
    assign bus.a_ctrl      = a_q;
    assign bus.b_ctrl      = b_q;
    assign bus.sd_ctrl     = sd_q;
    assign bus.stall_count = cnt_q;

endmodule
